// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave endpoint.
package spi_pkg;

  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses aligned to the
// synchronized level (pulse = synchronized value vs its previous value).
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned STAGES  = SPI_SYNC_STAGES,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // The pulse compares the value about to become `level` with the current one,
  // so rise/fall assert in the same cycle the synchronized level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      rise  <= chain[STAGES-2] & ~chain[STAGES-1];
      fall  <= ~chain[STAGES-2] & chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave endpoint, oversampled in the clk domain, with a one-entry
// transmit buffer and a one-cycle receive strobe.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun
);

  localparam int unsigned      CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_slv_state_t state, state_nxt;

  logic                   sclk_s, sclk_rise, sclk_fall;
  logic                   ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
  logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
  logic [DATA_W-1:0] tx_buf, tx_buf_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic              rx_valid_nxt, tx_underrun_nxt, tx_ready_nxt, miso_nxt;
  logic              load_c;
  logic              unused_sink;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ss_n),
    .level (ss_s),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // mosi needs only its level; same depth keeps it aligned with sclk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values; deselect takes priority over any sclk edge.
  always_comb begin
    bit_cnt_nxt     = bit_cnt;
    rx_shift_nxt    = rx_shift;
    tx_shift_nxt    = tx_shift;
    tx_buf_nxt      = tx_buf;
    rx_data_nxt     = rx_data;
    rx_valid_nxt    = 1'b0;
    tx_underrun_nxt = 1'b0;
    tx_ready_nxt    = tx_ready;
    load_c          = 1'b0;

    if (tx_wr && tx_ready) begin
      tx_buf_nxt   = tx_data;
      tx_ready_nxt = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          bit_cnt_nxt = '0;
          load_c      = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          bit_cnt_nxt = '0;
        end else if (sclk_rise) begin
          rx_shift_nxt = {rx_shift[DATA_W-2:0], mosi_s};
          if (bit_cnt == LAST_BIT) begin
            rx_data_nxt  = rx_shift_nxt;
            rx_valid_nxt = 1'b1;
            bit_cnt_nxt  = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
          load_c       = (bit_cnt == '0);
        end
      end
      default: ;
    endcase

    // Load never coincides with an accepted write: a full buffer blocks tx_wr.
    if (load_c) begin
      if (!tx_ready) begin
        tx_shift_nxt = tx_buf;
        tx_ready_nxt = 1'b1;
      end else begin
        tx_shift_nxt    = '0;
        tx_underrun_nxt = 1'b1;
      end
    end

    miso_nxt = (state_nxt == ACTIVE) ? tx_shift_nxt[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      tx_ready    <= 1'b1;
      miso        <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_nxt;
      rx_shift    <= rx_shift_nxt;
      tx_shift    <= tx_shift_nxt;
      tx_buf      <= tx_buf_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      tx_underrun <= tx_underrun_nxt;
      tx_ready    <= tx_ready_nxt;
      miso        <= miso_nxt;
    end
  end

  assign unused_sink = ^{sclk_s, ss_s, rx_shift[DATA_W-1]};

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed plus randomized bench for spi_slave_if against a byte-level model
// of the transmit buffer, underrun rule and received-byte stream.
module tb_spi_slave_if;
  import spi_pkg::*;

  localparam int unsigned W    = SPI_DATA_W;
  localparam int unsigned S    = SPI_SYNC_STAGES;
  localparam int unsigned HALF = S + 4;

  logic         clk = 1'b0;
  logic         rst_n, sclk, ss_n, mosi, miso;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_wr, tx_ready, rx_valid, tx_underrun;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int und_cnt  = 0;
  int exp_und  = 0;
  int lat;
  logic [W-1:0] rx_q[$];

  // Byte-level model of the one-entry transmit buffer.
  bit           m_full = 1'b0;
  logic [W-1:0] m_buf  = '0;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun)
  );

  always @(negedge clk) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (tx_underrun) und_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_write(input logic [W-1:0] d);
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = d;
    end
  endtask

  task automatic model_load(output logic [W-1:0] b);
    if (m_full) begin
      b      = m_buf;
      m_full = 1'b0;
    end else begin
      b = '0;
      exp_und++;
    end
  endtask

  task automatic host_wr(input logic [W-1:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    model_write(d);
  endtask

  // Mode-0 master: ss_n rises while sclk is still high after the last bit.
  task automatic frame(input int nbits, input logic [15:0] mo, input bit mid_wr,
                       input logic [W-1:0] mid_d, output logic [15:0] mi);
    mi   = '0;
    ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[nbits-1-i];
      if (mid_wr && i == 3) begin
        host_wr(mid_d);
        wait_cyc(HALF - 1);
      end else begin
        wait_cyc(HALF);
      end
      mi   = {mi[14:0], miso};
      sclk = 1'b1;
      for (int k = 1; k <= int'(HALF); k++) begin
        @(negedge clk);
        if (rx_valid && lat < 0) lat = k;
      end
      if (i != nbits - 1) sclk = 1'b0;
    end
    ss_n = 1'b1;
    wait_cyc(HALF);
    sclk = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic check_rx(input string tag, input int n, input logic [15:0] exp_bytes);
    check({tag, "_rx_count"}, rx_q.size(), n);
    for (int j = n - 1; j >= 0; j--) begin
      if (rx_q.size() > 0) check({tag, "_rx_byte"}, rx_q.pop_front(), exp_bytes[j*8 +: 8]);
    end
    rx_q.delete();
  endtask

  initial begin
    logic [W-1:0]  t0, t1, mo8, last_rx;
    logic [15:0]   mi, mo16;
    bit            wr;

    rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_wr = 1'b0; tx_data = '0;
    wait_cyc(3);
    check("reset_miso", miso, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_underrun", tx_underrun, 0);
    rst_n = 1'b1;
    wait_cyc(3);

    // Receive 0xA5 with an empty buffer
    model_load(t0);
    lat = -1;
    frame(8, 16'h00A5, 1'b0, '0, mi);
    check_rx("recv", 1, 16'h00A5);
    check("recv_rx_data", rx_data, 8'hA5);
    check("recv_underrun", und_cnt, exp_und);
    check("recv_miso", mi[7:0], t0);
    check("recv_latency", lat, S + 1);

    // Transmit 0x3C
    host_wr(8'h3C);
    check("tx_ready_full", tx_ready, 0);
    check("idle_miso", miso, 0);
    model_load(t0);
    mo8 = W'($urandom);
    frame(8, {8'h00, mo8}, 1'b0, '0, mi);
    check("tx_miso", mi[7:0], t0);
    check("tx_ready_after", tx_ready, 1);
    check("tx_underrun", und_cnt, exp_und);
    check_rx("tx", 1, {8'h00, mo8});

    // Back-to-back bytes, second byte written mid-frame
    host_wr(8'h91);
    model_load(t0);
    mo16 = 16'($urandom);
    frame(16, mo16, 1'b1, 8'hF0, mi);
    model_load(t1);
    check("b2b_miso", mi, {t0, t1});
    check("b2b_underrun", und_cnt, exp_und);
    check_rx("b2b", 2, mo16);
    last_rx = mo16[7:0];

    // Abort after 3 bits, then a full frame
    model_load(t0);
    frame(3, 16'h0005, 1'b0, '0, mi);
    check_rx("abort", 0, 16'h0000);
    check("abort_rx_data", rx_data, last_rx);
    check("abort_underrun", und_cnt, exp_und);
    model_load(t0);
    frame(8, 16'h0012, 1'b0, '0, mi);
    check_rx("after_abort", 1, 16'h0012);
    check("after_abort_rx_data", rx_data, 8'h12);

    // Write while full
    host_wr(8'h55);
    host_wr(8'hAA);
    check("wfull_tx_ready", tx_ready, 0);
    model_load(t0);
    mo8 = W'($urandom) | 8'h01;
    frame(8, {8'h00, mo8}, 1'b0, '0, mi);
    check("wfull_miso", mi[7:0], t0);
    check("wfull_tx_ready_after", tx_ready, 1);
    check_rx("wfull", 1, {8'h00, mo8});

    // Reset mid-frame after 5 bits
    host_wr(8'hFF);
    model_load(t0);
    ss_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      if (i == 2) begin
        host_wr(8'h77);
        wait_cyc(HALF - 1);
      end else begin
        wait_cyc(HALF);
      end
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
    wait_cyc(HALF);
    check("mid_miso", miso, t0[W-6]);
    check("mid_tx_ready", tx_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    m_full = 1'b0;
    rx_q.delete();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    model_load(t0);
    frame(8, 16'h000F, 1'b0, '0, mi);
    check_rx("post_rst", 1, 16'h000F);
    check("post_rst_miso", mi[7:0], t0);
    check("post_rst_underrun", und_cnt, exp_und);

    // Randomized frames against the model
    for (int r = 0; r < 8; r++) begin
      wr  = 1'($urandom);
      mo8 = W'($urandom);
      if (wr) host_wr(W'($urandom));
      model_load(t0);
      frame(8, {8'h00, mo8}, 1'b0, '0, mi);
      check("rand_miso", mi[7:0], t0);
      check("rand_underrun", und_cnt, exp_und);
      check("rand_tx_ready", tx_ready, 1);
      check_rx("rand", 1, {8'h00, mo8});
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
